// File: rtl/pattern_player.sv
// Replays a stored pattern set into a DUT, checks each masked response against
// its expected value and compacts all masked responses into a 16-bit MISR.
module pattern_player #(
    parameter int PAT_W  = 2,
    parameter int RSP_W  = 1,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [PAT_W-1:0]  ld_pat,
    input  logic [RSP_W-1:0]  ld_exp,
    input  logic [RSP_W-1:0]  ld_mask,
    input  logic [ADDR_W:0]   num_pats,
    input  logic              start,
    output logic [PAT_W-1:0]  pat_out,
    input  logic [RSP_W-1:0]  rsp_in,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   fail_cnt,
    output logic [ADDR_W-1:0] first_fail,
    output logic              ff_valid,
    output logic [15:0]       signature
);
    localparam int          CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [15:0] SIG_SEED = 16'hFFFF;
    localparam logic [15:0] SIG_POLY = 16'h1021;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CAPTURE, S_DONE} state_e;

    typedef struct packed {
        logic [PAT_W-1:0] pat;
        logic [RSP_W-1:0] rsp_exp;
        logic [RSP_W-1:0] rsp_mask;
    } entry_t;

    entry_t mem [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [ADDR_W:0]   fail_q, fail_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic              ffv_q, ffv_d;
    logic [15:0]       sig_q, sig_d;

    logic              wr_en;
    logic [ADDR_W-1:0] idx_inc;
    logic [PAT_W-1:0]  head_pat;
    logic              miscmp;
    entry_t            cur;

    assign busy    = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CAPTURE);
    assign done    = (state_q == S_DONE);
    assign wr_en   = ld_en && !busy;
    assign idx_inc = idx_q + ADDR_W'(1);
    assign cur     = mem[idx_q];
    assign miscmp  = |((rsp_in ^ cur.rsp_exp) & cur.rsp_mask);
    // A load landing on the start edge must be seen by the first APPLY.
    assign head_pat = (wr_en && (ld_addr == '0)) ? ld_pat : mem[0].pat;

    // NOTE: pattern storage has no reset; contents must survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ld_addr] <= '{pat: ld_pat, rsp_exp: ld_exp, rsp_mask: ld_mask};
        end
    end

    // NOTE: every variable gets its default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        fail_d  = fail_q;
        first_d = first_q;
        ffv_d   = ffv_q;
        sig_d   = sig_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d   = '0;
                    fail_d  = '0;
                    ffv_d   = 1'b0;
                    first_d = '0;
                    sig_d   = SIG_SEED;
                    if (num_pats == '0) begin
                        state_d = S_DONE;
                    end else begin
                        last_d  = (num_pats > DEPTH_V) ? ADDR_W'(DEPTH - 1)
                                                       : ADDR_W'(num_pats - 1'b1);
                        pat_d   = head_pat;
                        state_d = S_APPLY;
                    end
                end
            end
            S_APPLY: begin
                cnt_d   = '0;
                state_d = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) state_d = S_CAPTURE;
                else                             cnt_d   = cnt_q + CNT_W'(1);
            end
            S_CAPTURE: begin
                if (miscmp) begin
                    fail_d = (&fail_q) ? fail_q : fail_q + (ADDR_W + 1)'(1);
                    if (!ffv_q) begin
                        first_d = idx_q;
                        ffv_d   = 1'b1;
                    end
                end
                sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? SIG_POLY : 16'h0000)
                        ^ 16'(rsp_in & cur.rsp_mask);
                if (idx_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_inc;
                    pat_d   = mem[idx_inc].pat;
                    state_d = S_APPLY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            fail_q  <= '0;
            first_q <= '0;
            ffv_q   <= 1'b0;
            sig_q   <= SIG_SEED;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            fail_q  <= fail_d;
            first_q <= first_d;
            ffv_q   <= ffv_d;
            sig_q   <= sig_d;
        end
    end

    assign pat_out    = pat_q;
    assign fail_cnt   = fail_q;
    assign first_fail = first_q;
    assign ff_valid   = ffv_q;
    assign signature  = sig_q;
endmodule
